store_align_queue: RTL and testbench

// - Parametrised store-path successor to the combinational byte-mask generator. It sits between the MEM-stage store issue and the data-memory write port.
// - Queues store requests. Each request is turned into aligned bus beats, each with a byte mask and lane-shifted write data.
// - A store that crosses a bus-word boundary is split into two beats.
// - Handshakes on both sides use valid/ready.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/store_align_queue_if.sv | 31 +++
 rtl/sync_fifo.sv | 47 ++++
 rtl/store_align_queue.sv | 162 ++++++++++++++++
 tb/tb_store_align_queue.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the store path: width codes, their byte sizes,
// and the beat sequencer state encoding.
package mem_pkg;

  localparam logic [2:0] MW_NONE  = 3'b000;
  localparam logic [2:0] MW_D     = 3'b001;
  localparam logic [2:0] MW_W     = 3'b010;
  localparam logic [2:0] MW_H     = 3'b011;
  localparam logic [2:0] MW_B     = 3'b100;
  localparam logic [2:0] MW_W_ALT = 3'b101;
  localparam logic [2:0] MW_H_ALT = 3'b110;
  localparam logic [2:0] MW_B_ALT = 3'b111;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} sq_state_e;

  // Store size in bytes for a width code; 0 for "no store".
  function automatic logic [3:0] width_bytes(input logic [2:0] code);
    case (code)
      MW_D:             width_bytes = 4'd8;
      MW_W, MW_W_ALT:   width_bytes = 4'd4;
      MW_H, MW_H_ALT:   width_bytes = 4'd2;
      MW_B, MW_B_ALT:   width_bytes = 4'd1;
      default:          width_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_align_queue_if.sv
// Request and memory-beat channels of the store alignment queue.
// master = store issue / memory environment, slave = the queue itself.
interface store_align_queue_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_width;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_mask;

  modport master (
    output req_valid, req_width, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_mask
  );

  modport slave (
    input  req_valid, req_width, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_mask
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Head is read combinationally; clr empties the queue and drops a
// same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/store_align_queue.sv
// Store alignment queue: buffers store requests and turns each into one
// or two NB-aligned write beats with byte mask and lane-shifted data.
module store_align_queue
  import mem_pkg::*;
#(
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 64,
  parameter int DEPTH          = 4,
  parameter int ALLOW_MISALIGN = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  store_align_queue_if.slave  bus,
  output logic                misalign_err,
  output logic                busy
);
  localparam int NB   = DATA_W / 8;
  localparam int OFFW = $clog2(NB);
  localparam int FW   = 3 + ADDR_W + DATA_W;

  // Lane mask spanning two bus words; upper half is the second beat.
  function automatic logic [2*NB-1:0] lane_mask(input logic [3:0] size,
                                                input logic [OFFW-1:0] off);
    logic [2*NB-1:0] ones;
    ones = ({{(2*NB-1){1'b0}}, 1'b1} << size) - 1'b1;
    return ones << off;
  endfunction

  // Data shifted into lanes across two bus words; upper half is the second beat.
  function automatic logic [2*DATA_W-1:0] lane_data(input logic [DATA_W-1:0] data,
                                                    input logic [OFFW-1:0]   off);
    return {{DATA_W{1'b0}}, data} << {off, 3'b000};
  endfunction

  logic              fifo_empty, fifo_full, push, pop;
  logic [FW-1:0]     head;
  logic [2:0]        h_code;
  logic [ADDR_W-1:0] h_addr, h_base;
  logic [DATA_W-1:0] h_data;
  logic [3:0]        h_size;
  logic [OFFW-1:0]   h_off;
  logic [4:0]        h_end;
  logic              h_cross, h_illegal, h_err;
  logic [2*NB-1:0]   h_mask_w;
  logic [2*DATA_W-1:0] h_data_w;

  sq_state_e         state, state_d;
  logic              cur_split, beat_done, free, load, to_beat1, err_d;
  logic [NB-1:0]     hi_mask;
  logic [DATA_W-1:0] hi_wdata;

  assign bus.req_ready = !fifo_full;
  assign push          = bus.req_valid && !fifo_full;

  sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .push  (push),
    .wdata ({bus.req_width, bus.req_addr, bus.req_data}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign h_code    = head[FW-1 -: 3];
  assign h_addr    = head[DATA_W +: ADDR_W];
  assign h_data    = head[DATA_W-1:0];
  assign h_size    = width_bytes(h_code);
  assign h_off     = h_addr[OFFW-1:0];
  assign h_base    = {h_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign h_end     = {{(5-OFFW){1'b0}}, h_off} + {1'b0, h_size};
  assign h_cross   = h_end > 5'(NB);
  // A doubleword cannot fit a 32-bit bus at all; a crossing store is only
  // legal when splitting is enabled.
  assign h_illegal = (h_code == MW_NONE) || (h_code == MW_D && NB == 4) ||
                     (h_cross && ALLOW_MISALIGN == 0);
  assign h_err     = h_illegal && (h_code != MW_NONE);
  assign h_mask_w  = lane_mask(h_size, h_off);
  assign h_data_w  = lane_data(h_data, h_off);

  assign bus.mem_valid = (state != IDLE);
  assign beat_done     = bus.mem_valid && bus.mem_ready;
  assign busy          = !fifo_empty || (state != IDLE);

  // Next-state: advance to the second beat of a split, otherwise take the
  // next head (loading or dropping it) as soon as the output is free.
  always_comb begin
    state_d  = state;
    free     = 1'b0;
    pop      = 1'b0;
    load     = 1'b0;
    to_beat1 = 1'b0;
    err_d    = 1'b0;
    case (state)
      IDLE:  free = 1'b1;
      BEAT0: if (beat_done) begin
               if (cur_split) begin
                 to_beat1 = 1'b1;
                 state_d  = BEAT1;
               end else begin
                 free = 1'b1;
               end
             end
      BEAT1: if (beat_done) free = 1'b1;
      default: free = 1'b1;
    endcase
    if (free) begin
      state_d = IDLE;
      if (!fifo_empty && !flush) begin
        pop = 1'b1;
        if (h_illegal) begin
          err_d = h_err;
        end else begin
          load    = 1'b1;
          state_d = BEAT0;
        end
      end
    end
  end

  // State register, split flag and registered error pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      cur_split    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_d;
      misalign_err <= err_d;
      if (load) cur_split <= h_cross;
    end
  end

  // Output beat register: first beat on load, second beat from held upper halves.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_mask  <= '0;
    end else if (load) begin
      bus.mem_addr  <= h_base;
      bus.mem_wdata <= h_data_w[DATA_W-1:0];
      bus.mem_mask  <= h_mask_w[NB-1:0];
    end else if (to_beat1) begin
      bus.mem_addr  <= bus.mem_addr + ADDR_W'(NB);
      bus.mem_wdata <= hi_wdata;
      bus.mem_mask  <= hi_mask;
    end
  end

  // Second-beat payload captured alongside the first beat.
  always_ff @(posedge clk) begin
    if (load) begin
      hi_wdata <= h_data_w[2*DATA_W-1:DATA_W];
      hi_mask  <= h_mask_w[2*NB-1:NB];
    end
  end

endmodule

// File: tb/tb_store_align_queue.sv
// Directed bench for store_align_queue (DATA_W=64, DEPTH=4): dut0 splits
// boundary-crossing stores, dut1 drops them.
module tb_store_align_queue;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic err0, busy0, err1, busy1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  store_align_queue_if #(.DATA_W(64), .ADDR_W(64)) if0 ();
  store_align_queue_if #(.DATA_W(64), .ADDR_W(64)) if1 ();

  store_align_queue #(.DATA_W(64), .ADDR_W(64), .DEPTH(4), .ALLOW_MISALIGN(1)) dut0 (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(if0), .misalign_err(err0), .busy(busy0));
  store_align_queue #(.DATA_W(64), .ADDR_W(64), .DEPTH(4), .ALLOW_MISALIGN(0)) dut1 (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(if1), .misalign_err(err1), .busy(busy1));

  // One request on dut0; starts and ends on a falling edge.
  task automatic push0(input logic [2:0] c, input logic [63:0] a, input logic [63:0] d);
    if0.req_valid = 1'b1; if0.req_width = c; if0.req_addr = a; if0.req_data = d;
    @(negedge clk);
    if0.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({if0.mem_valid, if0.mem_addr, if0.mem_wdata, if0.mem_mask, err0, busy0} !== '0)
      $display("FAIL reset_outputs: got v=%b a=%h d=%h m=%h e=%b b=%b, want all zero",
               if0.mem_valid, if0.mem_addr, if0.mem_wdata, if0.mem_mask, err0, busy0);
    else passed++;
    checks++;
    if (if0.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if0.req_ready);
    else passed++;
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_d();
    if0.mem_ready = 1'b1;
    push0(3'b001, 64'h1000, 64'h1122334455667788);
    @(negedge clk);
    checks++;
    if ({if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata} !==
        {1'b1, 64'h1000, 8'hFF, 64'h1122334455667788})
      $display("FAIL sd_beat: got v=%b a=%h m=%h d=%h want v=1 a=1000 m=ff d=1122334455667788",
               if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata);
    else passed++;
    @(negedge clk);
    checks++;
    if ({if0.mem_valid, busy0} !== 2'b00)
      $display("FAIL sd_done: got v=%b busy=%b want 0 0", if0.mem_valid, busy0);
    else passed++;
  endtask

  task automatic test_store_b();
    push0(3'b100, 64'h1005, 64'hAB);
    @(negedge clk);
    checks++;
    if ({if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata} !==
        {1'b1, 64'h1000, 8'h20, 64'h0000AB0000000000})
      $display("FAIL sb_beat: got v=%b a=%h m=%h d=%h want v=1 a=1000 m=20 d=0000ab0000000000",
               if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_split();
    if0.req_valid = 1'b1; if0.req_width = 3'b010; if0.req_addr = 64'h1006; if0.req_data = 64'hDEADBEEF;
    if1.req_valid = 1'b1; if1.req_width = 3'b010; if1.req_addr = 64'h1006; if1.req_data = 64'hDEADBEEF;
    @(negedge clk);
    if0.req_valid = 1'b0; if1.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata, err0} !==
        {1'b1, 64'h1000, 8'hC0, 64'hBEEF000000000000, 1'b0})
      $display("FAIL split_beat0: got v=%b a=%h m=%h d=%h e=%b want v=1 a=1000 m=c0 d=beef000000000000 e=0",
               if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata, err0);
    else passed++;
    checks++;
    if ({if1.mem_valid, err1} !== 2'b01)
      $display("FAIL drop_err_on: got v=%b err=%b want v=0 err=1", if1.mem_valid, err1);
    else passed++;
    @(negedge clk);
    checks++;
    if ({if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata} !==
        {1'b1, 64'h1008, 8'h03, 64'h000000000000DEAD})
      $display("FAIL split_beat1: got v=%b a=%h m=%h d=%h want v=1 a=1008 m=03 d=dead",
               if0.mem_valid, if0.mem_addr, if0.mem_mask, if0.mem_wdata);
    else passed++;
    checks++;
    if ({if1.mem_valid, err1, busy1} !== 3'b000)
      $display("FAIL drop_err_off: got v=%b err=%b busy=%b want 0 0 0", if1.mem_valid, err1, busy1);
    else passed++;
    @(negedge clk);
    checks++;
    if ({if0.mem_valid, busy0} !== 2'b00)
      $display("FAIL split_done: got v=%b busy=%b want 0 0", if0.mem_valid, busy0);
    else passed++;
  endtask

  task automatic test_none();
    logic seen_v, seen_e;
    seen_v = 1'b0; seen_e = 1'b0;
    push0(3'b000, 64'h1234, 64'h55);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_v |= if0.mem_valid; seen_e |= err0;
    end
    checks++;
    if ({seen_v, seen_e, busy0} !== 3'b000)
      $display("FAIL none_code: got beat=%b err=%b busy=%b want 0 0 0", seen_v, seen_e, busy0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]   codes [4];
    logic [63:0]  addrs [4];
    logic [63:0]  datas [4];
    logic [135:0] exp   [5];
    logic [135:0] got   [5];
    int n, first, last;
    codes = '{3'b101, 3'b110, 3'b111, 3'b011};
    addrs = '{64'h3000, 64'h3003, 64'h3007, 64'h3007};
    datas = '{64'h12345678, 64'hBEEF, 64'h5A, 64'hBEEF};
    exp[0] = {64'h3000, 8'h0F, 64'h0000000012345678};
    exp[1] = {64'h3000, 8'h18, 64'h000000BEEF000000};
    exp[2] = {64'h3000, 8'h80, 64'h5A00000000000000};
    exp[3] = {64'h3000, 8'h80, 64'hEF00000000000000};
    exp[4] = {64'h3008, 8'h01, 64'h00000000000000BE};
    n = 0; first = -1; last = -1;
    if0.mem_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (if0.mem_valid && n < 5) begin
        got[n] = {if0.mem_addr, if0.mem_mask, if0.mem_wdata};
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
      if (cyc < 4) begin
        if0.req_valid = 1'b1; if0.req_width = codes[cyc];
        if0.req_addr = addrs[cyc]; if0.req_data = datas[cyc];
      end else begin
        if0.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 5) $display("FAIL b2b_count: got %0d beats want 5", n);
    else passed++;
    checks++;
    if (last - first !== 4) $display("FAIL b2b_rate: beats spanned %0d cycles want 4", last - first);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        checks++;
        if (got[i] !== exp[i]) $display("FAIL b2b_beat%0d: got %h want %h", i, got[i], exp[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_full_stall();
    logic [135:0] snap, exp_b;
    logic         have_snap, took;
    int acc, unstable, n;
    acc = 0; unstable = 0; have_snap = 1'b0; took = 1'b0;
    if0.mem_ready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (took) acc++;
      if (if0.mem_valid) begin
        if (!have_snap) begin
          snap = {if0.mem_addr, if0.mem_mask, if0.mem_wdata};
          have_snap = 1'b1;
        end else if ({if0.mem_addr, if0.mem_mask, if0.mem_wdata} !== snap) begin
          unstable++;
        end
      end
      if (acc < 8) begin
        if0.req_valid = 1'b1; if0.req_width = 3'b100;
        if0.req_addr = 64'h2000 + 64'(acc); if0.req_data = 64'(acc + 1);
      end else begin
        if0.req_valid = 1'b0;
      end
      took = if0.req_valid && if0.req_ready;
      @(negedge clk);
    end
    if0.req_valid = 1'b0;
    checks++;
    if (acc !== 5) $display("FAIL full_accepted: got %0d want 5", acc);
    else passed++;
    checks++;
    if ({if0.req_ready, if0.mem_valid} !== 2'b01)
      $display("FAIL full_ready: got ready=%b valid=%b want 0 1", if0.req_ready, if0.mem_valid);
    else passed++;
    checks++;
    if (unstable !== 0 || !have_snap)
      $display("FAIL stall_stable: got %0d changes (beat seen=%b) want 0 changes", unstable, have_snap);
    else passed++;
    if0.mem_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (if0.mem_valid && if0.mem_ready) begin
        exp_b = {64'h2000, 8'(1 << n), 64'(n + 1) << (8 * n)};
        checks++;
        if ({if0.mem_addr, if0.mem_mask, if0.mem_wdata} !== exp_b)
          $display("FAIL drain_beat%0d: got %h want %h", n,
                   {if0.mem_addr, if0.mem_mask, if0.mem_wdata}, exp_b);
        else passed++;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 5 || busy0 !== 1'b0) $display("FAIL drain_count: got %0d beats busy=%b want 5 0", n, busy0);
    else passed++;
  endtask

  task automatic test_flush();
    int n;
    if0.mem_ready = 1'b0;
    push0(3'b100, 64'h4001, 64'h11);
    push0(3'b100, 64'h4002, 64'h22);
    push0(3'b100, 64'h4003, 64'h33);
    flush = 1'b1;
    if0.req_valid = 1'b1; if0.req_width = 3'b100; if0.req_addr = 64'h4004; if0.req_data = 64'h44;
    @(negedge clk);
    flush = 1'b0; if0.req_valid = 1'b0;
    checks++;
    if ({if0.mem_valid, if0.mem_addr, if0.mem_mask, busy0} !== {1'b1, 64'h4000, 8'h02, 1'b1})
      $display("FAIL flush_inflight: got v=%b a=%h m=%h busy=%b want v=1 a=4000 m=02 busy=1",
               if0.mem_valid, if0.mem_addr, if0.mem_mask, busy0);
    else passed++;
    if0.mem_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (if0.mem_valid && if0.mem_ready) n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 1 || busy0 !== 1'b0) $display("FAIL flush_beats: got %0d beats busy=%b want 1 0", n, busy0);
    else passed++;
  endtask

  task automatic test_reset_mid_split();
    logic seen_v;
    seen_v = 1'b0;
    if0.mem_ready = 1'b1;
    push0(3'b010, 64'h1006, 64'hDEADBEEF);
    @(negedge clk);
    if0.mem_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({if0.mem_valid, busy0, if0.mem_mask} !== 10'b0)
      $display("FAIL rst_mid_split: got v=%b busy=%b m=%h want 0 0 00", if0.mem_valid, busy0, if0.mem_mask);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    if0.mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen_v |= if0.mem_valid;
    end
    checks++;
    if (seen_v !== 1'b0) $display("FAIL rst_no_beat1: got beat=%b want 0", seen_v);
    else passed++;
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_width = 3'b000; if0.req_addr = '0; if0.req_data = '0; if0.mem_ready = 1'b1;
    if1.req_valid = 1'b0; if1.req_width = 3'b000; if1.req_addr = '0; if1.req_data = '0; if1.mem_ready = 1'b1;
    test_reset();
    test_store_d();
    test_store_b();
    test_split();
    test_none();
    test_back_to_back();
    test_full_stall();
    test_flush();
    test_reset_mid_split();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
